// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared state, opcode, ALU-op and immediate-select encodings for multicycle_control
package mc_pkg;

   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_MEM_ADDR = 4'd2,
      ST_MEM_RD   = 4'd3,
      ST_MEM_WB   = 4'd4,
      ST_MEM_WR   = 4'd5,
      ST_R_EXEC   = 4'd6,
      ST_R_WB     = 4'd7,
      ST_BRANCH   = 4'd8
   } mc_state_e;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_FUNCT = 2'b10
   } alu_op_e;

   // Also consumed by the immediate generator, so keep the encoding stable.
   typedef enum logic [1:0] {
      IMM_I  = 2'b00,
      IMM_S  = 2'b01,
      IMM_SB = 2'b10
   } imm_sel_e;

   localparam logic [1:0] SRCB_RS2     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_ALT = 2'b11;

   function automatic logic [6:0] opcode_of(input logic [31:0] ir);
      return ir[6:0];
   endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - IR/flag inputs and datapath control strobes of multicycle_control
interface multicycle_control_if;
   logic [31:0] instruction;
   logic        zero;
   logic        mem_ready;
   logic        pc_write;
   logic        pc_write_cond;
   logic        ir_write;
   logic        mem_read;
   logic        mem_write;
   logic        i_or_d;
   logic        reg_write;
   logic        mem_to_reg;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic [1:0]  alu_op;
   logic        pc_source;
   logic [1:0]  imm_sel;
   logic        illegal;

   modport master (
      input  instruction, zero, mem_ready,
      output pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d,
             reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
             imm_sel, illegal
   );

   modport slave (
      output instruction, zero, mem_ready,
      input  pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d,
             reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
             imm_sel, illegal
   );
endinterface

// File: rtl/mc_perf_counters.sv
// rtl/mc_perf_counters.sv - cycle and retired-instruction counters, built only with MC_PERF_COUNT_EN
`ifdef MC_PERF_COUNT_EN
module mc_perf_counters #(
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             retire_i,
   output logic [CNT_W-1:0] cycle_count_o,
   output logic [CNT_W-1:0] retire_count_o
);
   logic [CNT_W-1:0] cycle_q;
   logic [CNT_W-1:0] retire_q;

   // Free-running cycle count plus retire count; both wrap naturally.
   always_ff @(posedge clock) begin
      if (reset) begin
         cycle_q  <= '0;
         retire_q <= '0;
      end else begin
         cycle_q <= cycle_q + 1'b1;
         if (retire_i) begin
            retire_q <= retire_q + 1'b1;
         end
      end
   end

   assign cycle_count_o  = cycle_q;
   assign retire_count_o = retire_q;
endmodule
`endif

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle control FSM for ld/sd/beq/R-type; MC_PERF_COUNT_EN adds counters
module multicycle_control
   import mc_pkg::*;
#(
   parameter int         CNT_W     = 32,
   parameter logic [6:0] OP_LOAD   = OPC_LOAD,
   parameter logic [6:0] OP_STORE  = OPC_STORE,
   parameter logic [6:0] OP_BRANCH = OPC_BRANCH,
   parameter logic [6:0] OP_RTYPE  = OPC_RTYPE
) (
   input  logic             clock,
   input  logic             reset,
   multicycle_control_if.master bus
`ifdef MC_PERF_COUNT_EN
   ,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] retire_count
`endif
);
   mc_state_e  state_q, state_d;
   logic       illegal_q, illegal_d;
   logic [6:0] opcode;

   logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d;
   logic       reg_write, mem_to_reg, alu_src_a, pc_source;
   logic [1:0] alu_src_b;
   alu_op_e    alu_op;
   imm_sel_e   imm_sel;

   // Only the opcode steers sequencing; funct fields and zero belong to the datapath.
   logic unused_inputs;
   assign unused_inputs = ^{bus.instruction[31:7], bus.zero};

   assign opcode = opcode_of(bus.instruction);

   // State and the one-cycle illegal-opcode flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   // Next state and control strobes decoded from the current state.
   always_comb begin
      state_d       = state_q;
      illegal_d     = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      i_or_d        = 1'b0;
      reg_write     = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_RS2;
      alu_op        = ALU_ADD;
      pc_source     = 1'b0;
      imm_sel       = IMM_I;
      if (reset) begin
         // Present FETCH values but suppress every write strobe while in reset.
         mem_read  = 1'b1;
         alu_src_b = SRCB_FOUR;
      end else begin
         unique case (state_q)
            ST_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = SRCB_FOUR;
               if (bus.mem_ready) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
                  state_d  = ST_DECODE;
               end
            end
            ST_DECODE: begin
               // Precompute the branch target into ALUOut while decoding.
               alu_src_b = SRCB_IMM_ALT;
               imm_sel   = IMM_SB;
               if (opcode == OP_LOAD || opcode == OP_STORE) begin
                  state_d = ST_MEM_ADDR;
               end else if (opcode == OP_RTYPE) begin
                  state_d = ST_R_EXEC;
               end else if (opcode == OP_BRANCH) begin
                  state_d = ST_BRANCH;
               end else begin
                  state_d   = ST_FETCH;
                  illegal_d = 1'b1;
               end
            end
            ST_MEM_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = SRCB_IMM;
               if (opcode == OP_STORE) begin
                  imm_sel = IMM_S;
                  state_d = ST_MEM_WR;
               end else begin
                  imm_sel = IMM_I;
                  state_d = ST_MEM_RD;
               end
            end
            ST_MEM_RD: begin
               mem_read = 1'b1;
               i_or_d   = 1'b1;
               if (bus.mem_ready) begin
                  state_d = ST_MEM_WB;
               end
            end
            ST_MEM_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
               state_d    = ST_FETCH;
            end
            ST_MEM_WR: begin
               mem_write = 1'b1;
               i_or_d    = 1'b1;
               if (bus.mem_ready) begin
                  state_d = ST_FETCH;
               end
            end
            ST_R_EXEC: begin
               alu_src_a = 1'b1;
               alu_src_b = SRCB_RS2;
               alu_op    = ALU_FUNCT;
               state_d   = ST_R_WB;
            end
            ST_R_WB: begin
               reg_write = 1'b1;
               state_d   = ST_FETCH;
            end
            ST_BRANCH: begin
               alu_src_a     = 1'b1;
               alu_src_b     = SRCB_RS2;
               alu_op        = ALU_SUB;
               pc_write_cond = 1'b1;
               pc_source     = 1'b1;
               state_d       = ST_FETCH;
            end
            default: begin
               state_d = ST_FETCH;
            end
         endcase
      end
   end

   assign bus.pc_write      = pc_write;
   assign bus.pc_write_cond = pc_write_cond;
   assign bus.ir_write      = ir_write;
   assign bus.mem_read      = mem_read;
   assign bus.mem_write     = mem_write;
   assign bus.i_or_d        = i_or_d;
   assign bus.reg_write     = reg_write;
   assign bus.mem_to_reg    = mem_to_reg;
   assign bus.alu_src_a     = alu_src_a;
   assign bus.alu_src_b     = alu_src_b;
   assign bus.alu_op        = alu_op;
   assign bus.pc_source     = pc_source;
   assign bus.imm_sel       = imm_sel;
   assign bus.illegal       = illegal_q & ~reset;

`ifdef MC_PERF_COUNT_EN
   // An instruction retires on the edge that returns a completing state to FETCH.
   logic retire;
   assign retire = !reset && (state_d == ST_FETCH) &&
                   (state_q == ST_MEM_WB || state_q == ST_MEM_WR ||
                    state_q == ST_R_WB   || state_q == ST_BRANCH);

   mc_perf_counters #(.CNT_W(CNT_W)) u_perf (
      .clock          (clock),
      .reset          (reset),
      .retire_i       (retire),
      .cycle_count_o  (cycle_count),
      .retire_count_o (retire_count)
   );
`else
   localparam int unused_cnt_w = CNT_W;
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized self-checking bench for multicycle_control
module tb_multicycle_control;
   logic clock = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   int   cyc_m = 0;
   int   ret_m = 0;
   bit   ill_pending = 0;
   int   stall_pct = 0;
   int   mw_seen = 0;

   localparam logic [31:0] I_LD  = 32'h00813083;
   localparam logic [31:0] I_SD  = 32'h0020B423;
   localparam logic [31:0] I_BEQ = 32'h00208463;
   localparam logic [31:0] I_ADD = 32'h002081B3;
   localparam logic [31:0] I_ILL = 32'h0000007F;

   always #5 clock = ~clock;

   multicycle_control_if bus();

`ifdef MC_PERF_COUNT_EN
   logic [31:0] cycle_count, retire_count;
   multicycle_control #(.CNT_W(32)) dut (
      .clock(clock), .reset(reset), .bus(bus),
      .cycle_count(cycle_count), .retire_count(retire_count)
   );
`else
   multicycle_control #(.CNT_W(32)) dut (
      .clock(clock), .reset(reset), .bus(bus)
   );
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Control word: pcw pcwc irw mrd mwr iod rw m2r sa sb[2] aop[2] psrc imm[2]
   function automatic logic [15:0] cv(bit pcw, bit pcwc, bit irw, bit mrd, bit mwr, bit iod,
                                      bit rw, bit m2r, bit sa, logic [1:0] sb, logic [1:0] aop,
                                      bit psrc, logic [1:0] imm);
      return {pcw, pcwc, irw, mrd, mwr, iod, rw, m2r, sa, sb, aop, psrc, imm};
   endfunction

   function automatic logic [15:0] dut_vec();
      return {bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.mem_read, bus.mem_write,
              bus.i_or_d, bus.reg_write, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b,
              bus.alu_op, bus.pc_source, bus.imm_sel};
   endfunction

   function automatic logic [15:0] v_fetch(bit rdy);
      return cv(rdy, 0, rdy, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 2'b00);
   endfunction
   function automatic logic [15:0] v_addr(bit st);
      return cv(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, st ? 2'b01 : 2'b00);
   endfunction
   localparam logic [15:0] V_RST = 16'b0001_0000_0010_0000;

   function automatic bit next_mr();
      return $urandom_range(0, 99) >= stall_pct;
   endfunction

   // One clock: drive inputs after the falling edge, sample just after.
   task automatic step(input string tag, input bit rst, input bit mr, input bit z,
                       input logic [31:0] ins, input logic [15:0] exp);
      @(negedge clock);
      reset           = rst;
      bus.mem_ready   = mr;
      bus.zero        = z;
      bus.instruction = ins;
      #1;
      check({tag, ".ctl"}, 32'(dut_vec()), 32'(exp));
      check({tag, ".ill"}, 32'(bus.illegal), 32'(ill_pending && !rst));
`ifdef MC_PERF_COUNT_EN
      if (!rst) begin
         check({tag, ".cyc"}, cycle_count, 32'(cyc_m));
         check({tag, ".ret"}, retire_count, 32'(ret_m));
      end
`endif
      mw_seen += int'(bus.mem_write);
      ill_pending = 0;
      if (rst) begin
         cyc_m = 0;
         ret_m = 0;
      end else begin
         cyc_m++;
      end
   endtask

   // Walk one instruction through the phases its class requires.
   task automatic do_instr(input string tag, input logic [31:0] ins, input int data_stalls,
                           input bit z);
      logic [6:0] op;
      bit         mr;
      bit         st;
      int         n;
      op = ins[6:0];
      n  = 0;
      do begin
         mr = next_mr() || (n > 40);
         step({tag, ".fetch"}, 0, mr, 1'($urandom), ins, v_fetch(mr));
         n++;
      end while (!mr);
      step({tag, ".dec"}, 0, next_mr(), 1'($urandom), ins,
           cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 2'b10));
      if (op == 7'b0000011 || op == 7'b0100011) begin
         st = (op == 7'b0100011);
         step({tag, ".addr"}, 0, next_mr(), 1'($urandom), ins, v_addr(st));
         n = 0;
         do begin
            if (data_stalls > 0) begin
               mr = 0;
               data_stalls--;
            end else begin
               mr = next_mr() || (n > 40);
            end
            step({tag, ".mem"}, 0, mr, 1'($urandom), ins,
                 cv(0, 0, 0, !st, st, 1, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00));
            n++;
         end while (!mr);
         if (!st) begin
            step({tag, ".wb"}, 0, next_mr(), 1'($urandom), ins,
                 cv(0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 2'b00));
         end
         ret_m++;
      end else if (op == 7'b0110011) begin
         step({tag, ".rex"}, 0, next_mr(), 1'($urandom), ins,
              cv(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 0, 2'b00));
         step({tag, ".rwb"}, 0, next_mr(), 1'($urandom), ins,
              cv(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00));
         ret_m++;
      end else if (op == 7'b1100011) begin
         step({tag, ".br"}, 0, next_mr(), z, ins,
              cv(0, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 1, 2'b00));
         check({tag, ".pcload"}, 32'(bus.pc_write | (bus.pc_write_cond & bus.zero)), 32'(z));
         ret_m++;
      end else begin
         ill_pending = 1;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          mw0;
      logic [31:0] ins;
      logic [6:0]  op;
      bus.instruction = '0;
      bus.zero        = 1'b0;
      bus.mem_ready   = 1'b1;
      reset           = 1'b1;

      for (int i = 0; i < 3; i++) step("rst", 1, 1, 0, I_LD, V_RST);

      stall_pct = 0;
      do_instr("add", I_ADD, 0, 0);
      do_instr("ld", I_LD, 0, 0);
      do_instr("beq1", I_BEQ, 0, 1);
`ifdef MC_PERF_COUNT_EN
      @(posedge clock);
      #1;
      check("perf.cycles", cycle_count, 32'd12);
      check("perf.retired", retire_count, 32'd3);
`endif
      do_instr("beq0", I_BEQ, 0, 0);

      mw0 = mw_seen;
      do_instr("sd", I_SD, 3, 0);
      check("sd.mw_cycles", 32'(mw_seen - mw0), 32'd4);

      do_instr("ill", I_ILL, 0, 0);
      do_instr("after_ill", I_LD, 0, 0);

      // Reset while a load waits in its memory-read phase.
      step("rmr.fetch", 0, 1, 0, I_LD, v_fetch(1));
      step("rmr.dec", 0, 1, 0, I_LD, cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 2'b10));
      step("rmr.addr", 0, 1, 0, I_LD, v_addr(0));
      step("rmr.rst", 1, 1, 0, I_LD, V_RST);
      do_instr("rmr.next", I_ADD, 0, 0);

      stall_pct = 30;
      for (int k = 0; k < 300; k++) begin
         case ($urandom_range(0, 4))
            0: ins = {$urandom} & 32'hFFFF_FF80 | 32'h03;
            1: ins = {$urandom} & 32'hFFFF_FF80 | 32'h23;
            2: ins = {$urandom} & 32'hFFFF_FF80 | 32'h63;
            3: ins = {$urandom} & 32'hFFFF_FF80 | 32'h33;
            default: begin
               do begin
                  op = 7'($urandom);
               end while (op == 7'h03 || op == 7'h23 || op == 7'h63 || op == 7'h33);
               ins = ({$urandom} & 32'hFFFF_FF80) | {25'd0, op};
            end
         endcase
         do_instr("rnd", ins, 0, 1'($urandom));
      end
      step("tail", 0, 0, 0, I_ADD, v_fetch(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
